// File: rtl/mem_axi_master_if.sv
// mem_axi_master_if: core request/response and AXI4-Lite bus bundle for mem_axi_master
interface mem_axi_master_if;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [2:0]  axi_awprot, axi_arprot;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  modport master (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    output axi_araddr, axi_arvalid, axi_arprot, axi_rready
  );
  modport slave (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    input  axi_araddr, axi_arvalid, axi_arprot, axi_rready
  );
endinterface

// File: rtl/mem_axi_master.sv
// mem_axi_master: single-outstanding core load/store to AXI4-Lite master with alignment checks and phase timeout
module mem_axi_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  mem_axi_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, WADDR_DATA, WRESP, RADDR, RDATA, DONE} state_t;
  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] awaddr_q, araddr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  off_q, size_q;
  logic        sgn_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, resp_valid_q, resp_err_q;
  logic        misaligned, aw_ok, w_ok, wait_st, progress, tmo;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d, rext_d;
  logic [15:0] rsh;
  assign bus.req_ready   = state_q == IDLE && !rst;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.axi_awaddr  = awaddr_q;
  assign bus.axi_awvalid = awvalid_q;
  assign bus.axi_awprot  = 3'b000;
  assign bus.axi_wdata   = wdata_q;
  assign bus.axi_wstrb   = wstrb_q;
  assign bus.axi_wvalid  = wvalid_q;
  assign bus.axi_bready  = bready_q;
  assign bus.axi_araddr  = araddr_q;
  assign bus.axi_arvalid = arvalid_q;
  assign bus.axi_arprot  = 3'b000;
  assign bus.axi_rready  = rready_q;
  // request decode, load data extraction and phase-progress/timeout detection
  always_comb begin
    misaligned = bus.req_size == 2'd3 || (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                 (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
    strb_d  = bus.req_size == 2'd0 ? 4'b0001 << bus.req_addr[1:0] :
              bus.req_size == 2'd1 ? 4'b0011 << bus.req_addr[1:0] : 4'b1111;
    wdata_d = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} :
              bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    rsh     = 16'(bus.axi_rdata >> {off_q, 3'b000});
    rext_d  = size_q == 2'd0 ? {{24{sgn_q & rsh[7]}}, rsh[7:0]} :
              size_q == 2'd1 ? {{16{sgn_q & rsh[15]}}, rsh} : bus.axi_rdata;
    aw_ok    = !awvalid_q || bus.axi_awready;
    w_ok     = !wvalid_q || bus.axi_wready;
    wait_st  = state_q inside {WADDR_DATA, WRESP, RADDR, RDATA};
    progress = (state_q == WADDR_DATA && aw_ok && w_ok) || (state_q == WRESP && bus.axi_bvalid) ||
               (state_q == RADDR && bus.axi_arready) || (state_q == RDATA && bus.axi_rvalid);
    tmo      = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  end
  // transaction FSM; every bus-facing output is registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      {awaddr_q, araddr_q, wdata_q, rdata_q, wstrb_q, off_q, size_q} <= '0;
      {sgn_q, awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, resp_valid_q, resp_err_q} <= '0;
    end else if (wait_st && !progress && tmo) begin
      state_q <= DONE;
      cnt_q <= '0;
      {awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q} <= '0;
      resp_valid_q <= 1'b1;
      resp_err_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      cnt_q <= wait_st && !progress ? cnt_q + 1'b1 : '0;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          off_q <= bus.req_addr[1:0];
          size_q <= bus.req_size;
          sgn_q <= bus.req_signed;
          if (misaligned) begin
            state_q <= DONE;
            resp_valid_q <= 1'b1;
            resp_err_q <= 1'b1;
            rdata_q <= '0;
          end else if (bus.req_we) begin
            state_q <= WADDR_DATA;
            awaddr_q <= {bus.req_addr[31:2], 2'b00};
            wdata_q <= wdata_d;
            wstrb_q <= strb_d;
            awvalid_q <= 1'b1;
            wvalid_q <= 1'b1;
          end else begin
            state_q <= RADDR;
            araddr_q <= {bus.req_addr[31:2], 2'b00};
            arvalid_q <= 1'b1;
          end
        end
        WADDR_DATA: begin
          awvalid_q <= awvalid_q && !bus.axi_awready;
          wvalid_q <= wvalid_q && !bus.axi_wready;
          if (aw_ok && w_ok) begin
            state_q <= WRESP;
            bready_q <= 1'b1;
          end
        end
        WRESP: if (bus.axi_bvalid) begin
          state_q <= DONE;
          bready_q <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q <= bus.axi_bresp != 2'b00;
          rdata_q <= '0;
        end
        RADDR: if (bus.axi_arready) begin
          state_q <= RDATA;
          arvalid_q <= 1'b0;
          rready_q <= 1'b1;
        end
        RDATA: if (bus.axi_rvalid) begin
          state_q <= DONE;
          rready_q <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q <= bus.axi_rresp != 2'b00;
          rdata_q <= rext_d;
        end
        DONE: begin
          state_q <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_axi_master.sv
// tb_mem_axi_master: directed and randomized checks of mem_axi_master against a byte-lane reference model
module tb_mem_axi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_axi_master_if bus();
  mem_axi_master #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_strb(logic [31:0] a, int sz);
    logic [3:0] s = '0;
    for (int i = 0; i < (1 << sz); i++) s[int'(a % 4) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(logic [31:0] d, int sz);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % (1 << sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] rd, logic [31:0] a, int sz, bit sg);
    logic [31:0] v = rd >> (8 * (a % 4));
    if (sz == 0) begin
      v = v % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic request(logic [31:0] a, int sz, bit we, bit sg, logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_size = 2'(sz);
    bus.req_signed = sg;
    bus.req_wdata = d;
    chk("req_ready_idle", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic store(logic [31:0] a, int sz, logic [31:0] d, int awd, int wd, logic [1:0] br);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    request(a, sz, 1'b1, 1'b0, d);
    while (!(aw_done && w_done) && cyc < 20) begin
      chk("st_awvalid", bus.axi_awvalid, !aw_done);
      chk("st_wvalid", bus.axi_wvalid, !w_done);
      chk("st_bready_early", bus.axi_bready, 0);
      chk("st_busy", bus.req_ready, 0);
      chk("st_awaddr", bus.axi_awaddr, a - a % 4);
      chk("st_wstrb", bus.axi_wstrb, m_strb(a, sz));
      chk("st_wdata", bus.axi_wdata, m_wdata(d, sz));
      if (cyc == 0) chk("st_awprot", bus.axi_awprot, 0);
      bus.axi_awready = !aw_done && cyc >= awd;
      bus.axi_wready = !w_done && cyc >= wd;
      if (bus.axi_awready && bus.axi_awvalid) aw_done = 1;
      if (bus.axi_wready && bus.axi_wvalid) w_done = 1;
      @(negedge clk);
      cyc++;
    end
    bus.axi_awready = 1'b0;
    bus.axi_wready = 1'b0;
    chk("st_handshakes", aw_done && w_done, 1);
    chk("st_bready", bus.axi_bready, 1);
    chk("st_valids_low", {bus.axi_awvalid, bus.axi_wvalid}, 0);
    bus.axi_bvalid = 1'b1;
    bus.axi_bresp = br;
    @(negedge clk);
    bus.axi_bvalid = 1'b0;
    chk("st_resp_valid", bus.resp_valid, 1);
    chk("st_resp_err", bus.resp_err, br != 0);
    chk("st_bready_after", bus.axi_bready, 0);
    @(negedge clk);
    chk("st_resp_pulse", bus.resp_valid, 0);
    chk("st_resp_err_hold", bus.resp_err, br != 0);
  endtask

  task automatic load(logic [31:0] a, int sz, bit sg, logic [31:0] rd, int ard, int rdl, logic [1:0] rr);
    bit done = 0;
    int cyc = 0;
    logic [31:0] exp = m_load(rd, a, sz, sg);
    request(a, sz, 1'b0, sg, 32'h0);
    while (!done && cyc < 20) begin
      chk("ld_arvalid", bus.axi_arvalid, 1);
      chk("ld_rready_early", bus.axi_rready, 0);
      chk("ld_araddr", bus.axi_araddr, a - a % 4);
      chk("ld_awvalid", bus.axi_awvalid, 0);
      bus.axi_arready = cyc >= ard;
      if (bus.axi_arready && bus.axi_arvalid) done = 1;
      @(negedge clk);
      cyc++;
    end
    bus.axi_arready = 1'b0;
    chk("ld_ar_done", done, 1);
    for (int j = 0; j < rdl; j++) begin
      chk("ld_rready_wait", bus.axi_rready, 1);
      chk("ld_arvalid_low", bus.axi_arvalid, 0);
      @(negedge clk);
    end
    chk("ld_rready", bus.axi_rready, 1);
    bus.axi_rvalid = 1'b1;
    bus.axi_rdata = rd;
    bus.axi_rresp = rr;
    @(negedge clk);
    bus.axi_rvalid = 1'b0;
    chk("ld_resp_valid", bus.resp_valid, 1);
    chk("ld_resp_rdata", bus.resp_rdata, exp);
    chk("ld_resp_err", bus.resp_err, rr != 0);
    @(negedge clk);
    chk("ld_resp_pulse", bus.resp_valid, 0);
    chk("ld_rdata_hold", bus.resp_rdata, exp);
  endtask

  task automatic misaligned(logic [31:0] a, int sz, bit we);
    request(a, sz, we, 1'b0, 32'h1234_5678);
    chk("mis_no_ar", bus.axi_arvalid, 0);
    chk("mis_no_aw", {bus.axi_awvalid, bus.axi_wvalid}, 0);
    chk("mis_resp_valid", bus.resp_valid, 1);
    chk("mis_resp_err", bus.resp_err, 1);
    chk("mis_resp_rdata", bus.resp_rdata, 0);
    @(negedge clk);
    chk("mis_resp_pulse", bus.resp_valid, 0);
    chk("mis_idle", bus.req_ready, 1);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    int sz;
    {bus.req_valid, bus.req_we, bus.req_signed, bus.req_size, bus.req_addr, bus.req_wdata} = '0;
    {bus.axi_awready, bus.axi_wready, bus.axi_bvalid, bus.axi_bresp} = '0;
    {bus.axi_arready, bus.axi_rvalid, bus.axi_rresp, bus.axi_rdata} = '0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp", {bus.resp_valid, bus.resp_err}, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_valids", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready}, 0);
    chk("rst_addr", bus.axi_awaddr | bus.axi_araddr | bus.axi_wdata, 0);
    chk("rst_wstrb", bus.axi_wstrb, 0);
    rst = 1'b0;
    #1 chk("rel_req_ready", bus.req_ready, 1);
    @(negedge clk);
    store(32'h1004, 2, 32'hDEAD_BEEF, 0, 0, 2'b00);
    store(32'h1007, 0, 32'h0000_00A5, 3, 0, 2'b00);
    store(32'h2002, 1, 32'h0000_BEEF, 0, 2, 2'b10);
    load(32'h1002, 1, 1'b1, 32'h8001_1234, 0, 0, 2'b00);
    load(32'h1002, 1, 1'b0, 32'h8001_1234, 1, 2, 2'b00);
    load(32'h3003, 0, 1'b1, 32'h8F00_0000, 0, 1, 2'b11);
    misaligned(32'h1001, 2, 1'b0);
    misaligned(32'h1003, 1, 1'b1);
    misaligned(32'h1000, 3, 1'b0);
    request(32'h4000, 2, 1'b0, 1'b0, 32'h0);
    n = 0;
    while (bus.axi_arvalid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("to_arvalid_cycles", n, 8);
    chk("to_resp_valid", bus.resp_valid, 1);
    chk("to_resp_err", bus.resp_err, 1);
    chk("to_resp_rdata", bus.resp_rdata, 0);
    @(negedge clk);
    load(32'h4000, 2, 1'b0, 32'h0BAD_F00D, 0, 0, 2'b00);
    request(32'h5004, 2, 1'b1, 1'b0, 32'hCAFE_F00D);
    chk("rst_mid_awvalid", bus.axi_awvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valids", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.axi_arvalid, bus.axi_rready}, 0);
    chk("rst_mid_data", bus.axi_awaddr | bus.axi_wdata, 0);
    chk("rst_mid_wstrb", bus.axi_wstrb, 0);
    chk("rst_mid_req_ready", bus.req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rst_after_idle", {bus.req_ready, bus.resp_valid, bus.axi_awvalid}, 3'b100);
      @(negedge clk);
    end
    for (int t = 0; t < 30; t++) begin
      a = $urandom;
      sz = int'($urandom_range(0, 2));
      if (sz == 1) a[0] = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1)
        store(a, sz, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
      else
        load(a, sz, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
